// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants: symbolic mnemonic codes, R-type functs, opcodes
// and the loader FSM state type used by the instruction encoder.
package mips_isa_pkg;

  localparam logic [4:0] MN_ADD   = 5'd0;
  localparam logic [4:0] MN_ADDU  = 5'd1;
  localparam logic [4:0] MN_SUB   = 5'd2;
  localparam logic [4:0] MN_SUBU  = 5'd3;
  localparam logic [4:0] MN_AND   = 5'd4;
  localparam logic [4:0] MN_OR    = 5'd5;
  localparam logic [4:0] MN_XOR   = 5'd6;
  localparam logic [4:0] MN_NOR   = 5'd7;
  localparam logic [4:0] MN_SLT   = 5'd8;
  localparam logic [4:0] MN_SLTU  = 5'd9;
  localparam logic [4:0] MN_LW    = 5'd10;
  localparam logic [4:0] MN_SW    = 5'd11;
  localparam logic [4:0] MN_BEQ   = 5'd12;
  localparam logic [4:0] MN_BNE   = 5'd13;
  localparam logic [4:0] MN_ANDI  = 5'd14;
  localparam logic [4:0] MN_ORI   = 5'd15;
  localparam logic [4:0] MN_XORI  = 5'd16;
  localparam logic [4:0] MN_ADDI  = 5'd17;
  localparam logic [4:0] MN_ADDIU = 5'd18;
  localparam logic [4:0] MN_SLTI  = 5'd19;
  localparam logic [4:0] MN_SLTIU = 5'd20;
  localparam logic [4:0] MN_LAST  = 5'd20;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } enc_state_e;

endpackage

// File: rtl/mips_word_encode.sv
// Combinational mnemonic-to-machine-word translation. Codes above MN_LAST
// report legal=0 and yield a zero word.
module mips_word_encode
  import mips_isa_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  logic       rtype;
  logic [5:0] funct;
  logic [5:0] op;

  always_comb begin
    rtype = 1'b0;
    legal = 1'b1;
    funct = 6'b0;
    op    = OP_RTYPE;
    case (mnem)
      MN_ADD:   begin rtype = 1'b1; funct = FN_ADD;  end
      MN_ADDU:  begin rtype = 1'b1; funct = FN_ADDU; end
      MN_SUB:   begin rtype = 1'b1; funct = FN_SUB;  end
      MN_SUBU:  begin rtype = 1'b1; funct = FN_SUBU; end
      MN_AND:   begin rtype = 1'b1; funct = FN_AND;  end
      MN_OR:    begin rtype = 1'b1; funct = FN_OR;   end
      MN_XOR:   begin rtype = 1'b1; funct = FN_XOR;  end
      MN_NOR:   begin rtype = 1'b1; funct = FN_NOR;  end
      MN_SLT:   begin rtype = 1'b1; funct = FN_SLT;  end
      MN_SLTU:  begin rtype = 1'b1; funct = FN_SLTU; end
      MN_LW:    op = OP_LW;
      MN_SW:    op = OP_SW;
      MN_BEQ:   op = OP_BEQ;
      MN_BNE:   op = OP_BNE;
      MN_ANDI:  op = OP_ANDI;
      MN_ORI:   op = OP_ORI;
      MN_XORI:  op = OP_XORI;
      MN_ADDI:  op = OP_ADDI;
      MN_ADDIU: op = OP_ADDIU;
      MN_SLTI:  op = OP_SLTI;
      MN_SLTIU: op = OP_SLTIU;
      default:  legal = 1'b0;
    endcase

    // Immediates are passed through raw; rd only exists in the R-type format.
    if (rtype) begin
      word = {OP_RTYPE, rs, rt, rd, 5'b0, funct};
    end else if (legal) begin
      word = {op, rs, rt, imm};
    end else begin
      word = 32'h0;
    end
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Instruction-memory loader: encodes one symbolic instruction per handshake
// and writes it to consecutive word addresses through a stallable write port.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  enc_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W:0]   count_q;
  logic              err_q;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept;
  logic        at_last;
  logic        hs;
  logic        hs_legal;
  logic        hs_illegal;

  mips_word_encode u_encode (
    .mnem  (in_mnem),
    .rs    (in_rs),
    .rt    (in_rt),
    .rd    (in_rd),
    .imm   (in_imm),
    .word  (enc_word),
    .legal (enc_legal)
  );

  assign accept  = (state_q == ST_WRITE) && imem_ready;
  assign at_last = (addr_q == LAST_ADDR);

  // A new word may only be taken while the pending one drains this cycle and
  // has somewhere to go afterwards; the last slot must retire alone.
  assign in_ready = rst_n && !start &&
                    ((state_q == ST_IDLE) ||
                     ((state_q == ST_WRITE) && imem_ready && !at_last));

  assign hs         = in_valid && in_ready;
  assign hs_legal   = hs && enc_legal;
  assign hs_illegal = hs && !enc_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE;
      wdata_q <= 32'h0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (start) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE;
      wdata_q <= 32'h0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (hs_illegal) begin
        err_q <= 1'b1;
      end
      if (hs_legal) begin
        wdata_q <= enc_word;
      end
      case (state_q)
        ST_IDLE: begin
          if (hs_legal) begin
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (accept) begin
            count_q <= count_q + CNT_ONE;
            if (at_last) begin
              state_q <= ST_FULL;
            end else begin
              addr_q  <= addr_q + ADDR_ONE;
              state_q <= hs_legal ? ST_WRITE : ST_IDLE;
            end
          end
        end
        ST_FULL: begin
          state_q <= ST_FULL;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_we    = (state_q == ST_WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign full       = (state_q == ST_FULL);
  assign err        = err_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for the instruction encoder: vector table, directed corner cases and
// randomized traffic against a cycle-level behavioural model.
module tb_mips_instr_encoder;
  import mips_isa_pkg::*;

  localparam int MAW  = 8;
  localparam int SAW  = 2;
  localparam int MLAST = (1 << MAW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (ADDR_W=8)
  logic              m_rst_n, m_start, m_in_valid, m_in_ready, m_imem_we, m_imem_ready;
  logic              m_full, m_err;
  logic [4:0]        m_mnem, m_rs, m_rt, m_rd;
  logic [15:0]       m_imm;
  logic [MAW-1:0]    m_addr;
  logic [31:0]       m_wdata;
  logic [MAW:0]      m_count;

  // small instance (ADDR_W=2) for capacity corner cases
  logic              s_rst_n, s_start, s_in_valid, s_in_ready, s_imem_we, s_imem_ready;
  logic              s_full, s_err;
  logic [4:0]        s_mnem, s_rs, s_rt, s_rd;
  logic [15:0]       s_imm;
  logic [SAW-1:0]    s_addr;
  logic [31:0]       s_wdata;
  logic [SAW:0]      s_count;

  mips_instr_encoder #(.ADDR_W(MAW), .BASE_ADDR(0)) u_main (
    .clk(clk), .rst_n(m_rst_n), .start(m_start), .in_valid(m_in_valid),
    .in_ready(m_in_ready), .in_mnem(m_mnem), .in_rs(m_rs), .in_rt(m_rt),
    .in_rd(m_rd), .in_imm(m_imm), .imem_we(m_imem_we), .imem_addr(m_addr),
    .imem_wdata(m_wdata), .imem_ready(m_imem_ready), .count(m_count),
    .full(m_full), .err(m_err)
  );

  mips_instr_encoder #(.ADDR_W(SAW), .BASE_ADDR(0)) u_small (
    .clk(clk), .rst_n(s_rst_n), .start(s_start), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .in_mnem(s_mnem), .in_rs(s_rs), .in_rt(s_rt),
    .in_rd(s_rd), .in_imm(s_imm), .imem_we(s_imem_we), .imem_addr(s_addr),
    .imem_wdata(s_wdata), .imem_ready(s_imem_ready), .count(s_count),
    .full(s_full), .err(s_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ISA tables written straight from the instruction set definition
  int functs[10] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
  int opcs[11]   = '{35, 43, 4, 5, 12, 13, 14, 8, 9, 10, 11};

  // returns {legal, word}
  function automatic logic [32:0] ref_encode(input int mn, input int rs, input int rt,
                                             input int rd, input int imm);
    longint w;
    if (mn <= 9) begin
      w = (longint'(rs) << 21) + (longint'(rt) << 16) + (longint'(rd) << 11) + functs[mn];
      return {1'b1, w[31:0]};
    end else if (mn <= 20) begin
      w = (longint'(opcs[mn - 10]) << 26) + (longint'(rs) << 21) + (longint'(rt) << 16) + imm;
      return {1'b1, w[31:0]};
    end
    return 33'h0;
  endfunction

  // behavioural model of the main instance
  bit          mo_pend, mo_full, mo_err;
  logic [31:0] mo_word;
  int          mo_addr, mo_count;

  task automatic model_reset();
    mo_pend = 0; mo_full = 0; mo_err = 0; mo_word = 0; mo_addr = 0; mo_count = 0;
  endtask

  // Apply one cycle of inputs to the main instance, check it against the
  // model just before the edge, then advance the model across the edge.
  task automatic step(input bit v, input int mn, input int rs, input int rt, input int rd,
                      input int imm, input bit rdy, input bit st);
    bit exp_ready, acc, hs;
    logic [32:0] r;
    m_in_valid = v; m_mnem = 5'(mn); m_rs = 5'(rs); m_rt = 5'(rt); m_rd = 5'(rd);
    m_imm = 16'(imm); m_imem_ready = rdy; m_start = st;
    @(negedge clk);
    exp_ready = !mo_full && !st && (!mo_pend || (rdy && mo_addr != MLAST));
    chk("in_ready", m_in_ready, exp_ready);
    chk("imem_we", m_imem_we, mo_pend);
    if (mo_pend) begin
      chk("imem_addr", m_addr, mo_addr);
      chk("imem_wdata", m_wdata, mo_word);
    end
    chk("count", m_count, mo_count);
    chk("full", m_full, mo_full);
    chk("err", m_err, mo_err);
    if (st) begin
      model_reset();
    end else begin
      acc = mo_pend && rdy;
      hs  = v && exp_ready;
      if (acc) begin
        mo_count++;
        mo_pend = 0;
        if (mo_addr == MLAST) mo_full = 1;
        else mo_addr++;
      end
      if (hs) begin
        r = ref_encode(mn, rs, rt, rd, imm);
        if (r[32]) begin
          mo_pend = 1;
          mo_word = r[31:0];
        end else begin
          mo_err = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int mn; int rs; int rt; int rd; int imm;
    logic [31:0] word;
  } vec_t;
  vec_t tbl[12];

  initial begin
    logic [31:0] held_addr, held_data;
    int hs_cnt;

    tbl[0]  = '{0,  1,  2,  3,  0,       32'h00221820};  // add
    tbl[1]  = '{10, 4,  5,  0,  'h0010,  32'h8C850010};  // lw
    tbl[2]  = '{12, 1,  2,  0,  'hFFFF,  32'h1022FFFF};  // beq
    tbl[3]  = '{20, 0,  9,  0,  7,       32'h2C090007};  // sltiu
    tbl[4]  = '{7,  31, 0,  17, 0,       32'h03E08827};  // nor
    tbl[5]  = '{11, 29, 31, 5,  'h8000,  32'hAFBF8000};  // sw, rd ignored
    tbl[6]  = '{9,  2,  3,  4,  0,       32'h0043202B};  // sltu
    tbl[7]  = '{14, 7,  8,  31, 'h00FF,  32'h30E800FF};  // andi, rd ignored
    tbl[8]  = '{13, 3,  0,  0,  'h1234,  32'h14601234};  // bne
    tbl[9]  = '{18, 1,  1,  0,  'hFFFE,  32'h2421FFFE};  // addiu
    tbl[10] = '{2,  5,  6,  7,  0,       32'h00A63822};  // sub
    tbl[11] = '{16, 10, 11, 0,  'hABCD,  32'h394BABCD};  // xori

    m_rst_n = 0; m_start = 0; m_in_valid = 0; m_mnem = 0; m_rs = 0; m_rt = 0; m_rd = 0;
    m_imm = 0; m_imem_ready = 0;
    s_rst_n = 0; s_start = 0; s_in_valid = 0; s_mnem = 0; s_rs = 0; s_rt = 0; s_rd = 0;
    s_imm = 0; s_imem_ready = 0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", m_in_ready, 0);
    m_rst_n = 1; s_rst_n = 1;
    @(posedge clk); #1;
    chk("rst_ready", m_in_ready, 1);
    chk("rst_we", m_imem_we, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_wdata", m_wdata, 0);
    chk("rst_count", m_count, 0);
    chk("rst_full", m_full, 0);
    chk("rst_err", m_err, 0);

    // vector table streamed back-to-back
    for (int i = 0; i < 12; i++) begin
      step(1, tbl[i].mn, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm, 1, 0);
      chk("tbl_we", m_imem_we, 1);
      chk("tbl_addr", m_addr, i);
      chk("tbl_word", m_wdata, tbl[i].word);
      $display("vec %0d mnem %0d addr %0d word %h", i, tbl[i].mn, m_addr, m_wdata);
    end
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("tbl_count", m_count, 12);

    // stall during a pending ori
    step(1, 15, 3, 4, 0, 'h5A5A, 1, 0);
    held_addr = m_addr; held_data = m_wdata;
    chk("stall_word", m_wdata, 32'h34645A5A);
    for (int c = 0; c < 3; c++) begin
      step(1, 0, 1, 1, 1, 0, 0, 0);
      chk("stall_addr", m_addr, held_addr);
      chk("stall_data", m_wdata, held_data);
    end
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("stall_count", m_count, 13);

    // illegal mnemonic
    step(1, 25, 1, 2, 3, 'h1111, 1, 0);
    chk("ill_err", m_err, 1);
    chk("ill_we", m_imem_we, 0);
    step(1, 1, 6, 7, 8, 0, 1, 0);
    chk("ill_next_addr", m_addr, 13);
    chk("ill_next_we", m_imem_we, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0);

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      int mn;
      mn = ($urandom % 8 == 0) ? 21 + int'($urandom % 11) : int'($urandom % 21);
      step($urandom % 4 != 0, mn, $urandom % 32, $urandom % 32, $urandom % 32,
           $urandom % 65536, $urandom % 4 != 0, $urandom % 250 == 0);
    end

    // small instance: fill capacity
    s_in_valid = 1; s_mnem = MN_ADD; s_rs = 5'd1; s_rt = 5'd2; s_rd = 5'd3; s_imem_ready = 1;
    hs_cnt = 0;
    for (int c = 0; c < 12 && hs_cnt < 4; c++) begin
      @(negedge clk);
      if (s_in_ready) hs_cnt++;
      @(posedge clk); #1;
    end
    s_in_valid = 0;
    chk("fill_handshakes", hs_cnt, 4);
    for (int c = 0; c < 8 && !s_full; c++) begin
      @(posedge clk); #1;
    end
    chk("fill_full", s_full, 1);
    chk("fill_count", s_count, 4);
    s_in_valid = 1;
    @(negedge clk);
    chk("fill_ready", s_in_ready, 0);
    @(posedge clk); #1;
    chk("fill_we", s_imem_we, 0);
    s_start = 1;
    @(negedge clk);
    chk("start_ready", s_in_ready, 0);
    @(posedge clk); #1;
    s_start = 0;
    chk("start_count", s_count, 0);
    chk("start_full", s_full, 0);
    @(negedge clk);
    chk("after_start_ready", s_in_ready, 1);
    @(posedge clk); #1;
    s_in_valid = 0;
    chk("restart_we", s_imem_we, 1);
    chk("restart_addr", s_addr, 0);

    // start aborts a stalled pending write
    s_imem_ready = 0;
    @(posedge clk); #1;
    chk("abort_pending", s_imem_we, 1);
    s_start = 1; s_in_valid = 1;
    @(negedge clk);
    chk("abort_ready", s_in_ready, 0);
    @(posedge clk); #1;
    s_start = 0; s_in_valid = 0;
    chk("abort_we", s_imem_we, 0);
    chk("abort_count", s_count, 0);
    @(posedge clk); #1;
    chk("abort_no_xfer", s_imem_we, 0);

    // asynchronous reset drops a pending word at once
    s_in_valid = 1;
    @(posedge clk); #1;
    s_in_valid = 0;
    chk("areset_pending", s_imem_we, 1);
    #2 s_rst_n = 0;
    #1;
    chk("areset_we", s_imem_we, 0);
    chk("areset_ready", s_in_ready, 0);
    @(negedge clk);
    s_rst_n = 1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
